// File: rtl/mesh_boot_sequencer.sv
// -----------------------------------------------------------------------------
// mesh_boot_sequencer
//
// Purpose: brings up the cores of a ROW x COLUMN mesh after power-on. For every
// core enabled in the sampled mask it issues one reset command, waits a
// settle interval, then issues one start command carrying that core's program
// address. The commands drive the mesh configuration port.
//
// Optional build macro: MESH_BOOT_RT_CLEAR_EN
//   When defined, an extra phase before the reset phase walks every route-table
//   entry (PROG=1, data=0, address 0 .. 2^FLOW_BITS-1). When undefined, the
//   route-table ports and parameters are absent and go leads straight to the
//   reset phase.
//
// Ports:
//   clock               in   system clock
//   RST                 in   synchronous, active-low reset
//   go                  in   one-cycle request to start a boot sequence
//   core_mask           in   bit i=1 boots core i; sampled when go is accepted
//   busy                out  sequence in progress
//   done                out  high from completion until the next accepted go
//   cmd_valid           out  a command is presented this cycle
//   operation           out  4'b0011 reset, 4'b1010 start, 4'b0000 NOP
//   ON                  out  mesh enable, sticky once sequencing begins
//   core_ID             out  target core of the current (or last) command
//   core_reset          out  high on reset-phase command cycles
//   start               out  high on start-phase command cycles
//   prog_address        out  (core_ID << ADDR_SHIFT) | BOOT_OFFSET on starts
//   PROG                out  route-table programming strobe (optional)
//   route_table_address out  route-table entry being cleared (optional)
//   route_table_data    out  route-table write data, always 0 (optional)
// -----------------------------------------------------------------------------
module mesh_boot_sequencer #(
    parameter int          ROW           = 4,
    parameter int          COLUMN        = 4,
    parameter int          ADDR_SHIFT    = 16,
    parameter logic [31:0] BOOT_OFFSET   = 32'h10,
    parameter int          SETTLE_CYCLES = 4
`ifdef MESH_BOOT_RT_CLEAR_EN
    ,
    parameter int          FLOW_BITS     = 6,
    parameter int          RT_WIDTH      = 4
`endif
) (
    input  logic                        clock,
    input  logic                        RST,
    input  logic                        go,
    input  logic [ROW*COLUMN-1:0]       core_mask,
    output logic                        busy,
    output logic                        done,
    output logic                        cmd_valid,
    output logic [3:0]                  operation,
    output logic                        ON,
    output logic [((ROW*COLUMN > 1) ? $clog2(ROW*COLUMN) : 1)-1:0] core_ID,
    output logic                        core_reset,
    output logic                        start,
    output logic [31:0]                 prog_address
`ifdef MESH_BOOT_RT_CLEAR_EN
    ,
    output logic                        PROG,
    output logic [FLOW_BITS-1:0]        route_table_address,
    output logic [RT_WIDTH-1:0]         route_table_data
`endif
);

    localparam int NUM_CORES = ROW * COLUMN;
    localparam int ID_BITS   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // The settle counter runs SETTLE_CYCLES-1 .. 0, one visible idle cycle per value.
    localparam logic [SET_W-1:0] SETTLE_LOAD =
        SET_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_RESET = 4'b0011;
    localparam logic [3:0] OP_START = 4'b1010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RT_CLEAR,
        S_RESET_PH,
        S_SETTLE,
        S_START_PH,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [NUM_CORES-1:0]   mask_q;
    logic [SET_W-1:0]       settle_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   cmd_valid_q;
    logic [3:0]             operation_q;
    logic                   on_q;
    logic [ID_BITS-1:0]     core_id_q;
    logic                   core_reset_q;
    logic                   start_q;
    logic [31:0]            prog_address_q;
`ifdef MESH_BOOT_RT_CLEAR_EN
    logic                   prog_q;
    logic [FLOW_BITS-1:0]   rt_addr_q;
`endif

    // Lowest set bit of a mask: {found, index}.
    function automatic logic [ID_BITS:0] lowest_set(input logic [NUM_CORES-1:0] m);
        logic [ID_BITS:0] r;
        r = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = {1'b1, ID_BITS'(i)};
            end
        end
        return r;
    endfunction

    // Program address in 32 bits; bits shifted past bit 31 are dropped.
    function automatic logic [31:0] start_addr(input logic [ID_BITS-1:0] idx);
        logic [31:0] a;
        a = 32'(idx) << ADDR_SHIFT;
        return a | BOOT_OFFSET;
    endfunction

    // Enabled cores strictly above the one just issued. Picking the lowest of
    // these lets masked-out cores be skipped without spending a cycle on them.
    logic [NUM_CORES-1:0] above_mask;
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_above
            assign above_mask[gi] = mask_q[gi] && (ID_BITS'(gi) > core_id_q);
        end
    endgenerate

    logic [ID_BITS:0] go_pick;     // first core of the incoming mask
    logic [ID_BITS:0] first_pick;  // first core of the latched mask
    logic [ID_BITS:0] next_pick;   // next core after the current one

    assign go_pick    = lowest_set(core_mask);
    assign first_pick = lowest_set(mask_q);
    assign next_pick  = lowest_set(above_mask);

    always_ff @(posedge clock) begin
        if (!RST) begin
            state_q        <= S_IDLE;
            mask_q         <= '0;
            settle_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cmd_valid_q    <= 1'b0;
            operation_q    <= OP_NOP;
            on_q           <= 1'b0;
            core_id_q      <= '0;
            core_reset_q   <= 1'b0;
            start_q        <= 1'b0;
            prog_address_q <= '0;
`ifdef MESH_BOOT_RT_CLEAR_EN
            prog_q         <= 1'b0;
            rt_addr_q      <= '0;
`endif
        end else begin
            // Command outputs are single-cycle; core_id_q deliberately holds.
            cmd_valid_q    <= 1'b0;
            operation_q    <= OP_NOP;
            core_reset_q   <= 1'b0;
            start_q        <= 1'b0;
            prog_address_q <= '0;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        mask_q <= core_mask;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        on_q   <= 1'b1;
`ifdef MESH_BOOT_RT_CLEAR_EN
                        state_q   <= S_RT_CLEAR;
                        prog_q    <= 1'b1;
                        rt_addr_q <= '0;
`else
                        // Search the incoming mask so the first command
                        // appears the cycle after go.
                        if (go_pick[ID_BITS]) begin
                            state_q      <= S_RESET_PH;
                            cmd_valid_q  <= 1'b1;
                            operation_q  <= OP_RESET;
                            core_reset_q <= 1'b1;
                            core_id_q    <= go_pick[ID_BITS-1:0];
                        end else if (SETTLE_CYCLES != 0) begin
                            state_q  <= S_SETTLE;
                            settle_q <= SETTLE_LOAD;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
`endif
                    end
                end

`ifdef MESH_BOOT_RT_CLEAR_EN
                S_RT_CLEAR: begin
                    if (rt_addr_q == '1) begin
                        prog_q    <= 1'b0;
                        rt_addr_q <= '0;
                        if (first_pick[ID_BITS]) begin
                            state_q      <= S_RESET_PH;
                            cmd_valid_q  <= 1'b1;
                            operation_q  <= OP_RESET;
                            core_reset_q <= 1'b1;
                            core_id_q    <= first_pick[ID_BITS-1:0];
                        end else if (SETTLE_CYCLES != 0) begin
                            state_q  <= S_SETTLE;
                            settle_q <= SETTLE_LOAD;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        rt_addr_q <= rt_addr_q + FLOW_BITS'(1);
                    end
                end
`endif

                S_RESET_PH: begin
                    if (next_pick[ID_BITS]) begin
                        cmd_valid_q  <= 1'b1;
                        operation_q  <= OP_RESET;
                        core_reset_q <= 1'b1;
                        core_id_q    <= next_pick[ID_BITS-1:0];
                    end else if (SETTLE_CYCLES != 0) begin
                        state_q  <= S_SETTLE;
                        settle_q <= SETTLE_LOAD;
                    end else if (first_pick[ID_BITS]) begin
                        // No settle interval: first start follows the last reset.
                        state_q        <= S_START_PH;
                        cmd_valid_q    <= 1'b1;
                        operation_q    <= OP_START;
                        start_q        <= 1'b1;
                        core_id_q      <= first_pick[ID_BITS-1:0];
                        prog_address_q <= start_addr(first_pick[ID_BITS-1:0]);
                    end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (settle_q == '0) begin
                        if (first_pick[ID_BITS]) begin
                            state_q        <= S_START_PH;
                            cmd_valid_q    <= 1'b1;
                            operation_q    <= OP_START;
                            start_q        <= 1'b1;
                            core_id_q      <= first_pick[ID_BITS-1:0];
                            prog_address_q <= start_addr(first_pick[ID_BITS-1:0]);
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        settle_q <= settle_q - SET_W'(1);
                    end
                end

                S_START_PH: begin
                    if (next_pick[ID_BITS]) begin
                        cmd_valid_q    <= 1'b1;
                        operation_q    <= OP_START;
                        start_q        <= 1'b1;
                        core_id_q      <= next_pick[ID_BITS-1:0];
                        prog_address_q <= start_addr(next_pick[ID_BITS-1:0]);
                    end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign cmd_valid    = cmd_valid_q;
    assign operation    = operation_q;
    assign ON           = on_q;
    assign core_ID      = core_id_q;
    assign core_reset   = core_reset_q;
    assign start        = start_q;
    assign prog_address = prog_address_q;
`ifdef MESH_BOOT_RT_CLEAR_EN
    assign PROG                = prog_q;
    assign route_table_address = rt_addr_q;
    assign route_table_data    = '0;
`endif

endmodule

// File: tb/tb_mesh_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mesh_boot_sequencer
//
// Directed bench for mesh_boot_sequencer at default parameters (4x4 mesh,
// ADDR_SHIFT=16, BOOT_OFFSET=32'h10, SETTLE_CYCLES=4). For each boot request
// the bench builds the full cycle-by-cycle expected output schedule into a
// queue, then pops and compares one entry per clock after go.
// -----------------------------------------------------------------------------
module tb_mesh_boot_sequencer;

    localparam int SETTLE = 4;
`ifdef MESH_BOOT_RT_CLEAR_EN
    localparam int RTC = 64;
`else
    localparam int RTC = 0;
`endif

    logic        clock;
    logic        RST;
    logic        go;
    logic [15:0] core_mask;
    logic        busy;
    logic        done;
    logic        cmd_valid;
    logic [3:0]  operation;
    logic        ON;
    logic [3:0]  core_ID;
    logic        core_reset;
    logic        start;
    logic [31:0] prog_address;
`ifdef MESH_BOOT_RT_CLEAR_EN
    logic        PROG;
    logic [5:0]  route_table_address;
    logic [3:0]  route_table_data;
`endif

    mesh_boot_sequencer dut (
        .clock        (clock),
        .RST          (RST),
        .go           (go),
        .core_mask    (core_mask),
        .busy         (busy),
        .done         (done),
        .cmd_valid    (cmd_valid),
        .operation    (operation),
        .ON           (ON),
        .core_ID      (core_ID),
        .core_reset   (core_reset),
        .start        (start),
        .prog_address (prog_address)
`ifdef MESH_BOOT_RT_CLEAR_EN
        ,
        .PROG                (PROG),
        .route_table_address (route_table_address),
        .route_table_data    (route_table_data)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic        rst;
        logic        st;
        logic [31:0] addr;
        logic [3:0]  id;
        logic        busy;
        logic        done;
        logic        on;
`ifdef MESH_BOOT_RT_CLEAR_EN
        logic        prog;
        logic [5:0]  rta;
        logic [3:0]  rtd;
`endif
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic [3:0] exp_last_id = 4'd0;

    function automatic obs_t sample();
        obs_t o;
        o.valid = cmd_valid;
        o.op    = operation;
        o.rst   = core_reset;
        o.st    = start;
        o.addr  = prog_address;
        o.id    = core_ID;
        o.busy  = busy;
        o.done  = done;
        o.on    = ON;
`ifdef MESH_BOOT_RT_CLEAR_EN
        o.prog  = PROG;
        o.rta   = route_table_address;
        o.rtd   = route_table_data;
`endif
        return o;
    endfunction

    task automatic check(input string tag, input int cyc, input obs_t e);
        obs_t o;
        o = sample();
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
        end
    endtask

    // Expected schedule for one boot, from the cycle after go onward.
    task automatic build_expect(input logic [15:0] m);
        obs_t e;
        e      = '0;
        e.busy = 1'b1;
        e.on   = 1'b1;
        e.id   = exp_last_id;
`ifdef MESH_BOOT_RT_CLEAR_EN
        for (int a = 0; a < 64; a++) begin
            e.prog = 1'b1;
            e.rta  = 6'(a);
            exp_q.push_back(e);
        end
        e.prog = 1'b0;
        e.rta  = '0;
`endif
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                e.valid = 1'b1; e.op = 4'b0011; e.rst = 1'b1; e.st = 1'b0;
                e.addr = 32'd0; e.id = 4'(i);
                exp_q.push_back(e);
            end
        end
        e.valid = 1'b0; e.op = 4'b0000; e.rst = 1'b0; e.st = 1'b0; e.addr = 32'd0;
        for (int s = 0; s < SETTLE; s++) exp_q.push_back(e);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                e.valid = 1'b1; e.op = 4'b1010; e.rst = 1'b0; e.st = 1'b1;
                e.addr = (32'(i) << 16) | 32'h10; e.id = 4'(i);
                exp_q.push_back(e);
            end
        end
        e.valid = 1'b0; e.op = 4'b0000; e.st = 1'b0; e.addr = 32'd0;
        e.busy  = 1'b0; e.done = 1'b1;
        exp_q.push_back(e);
        exp_last_id = e.id;
    endtask

    // Called at a negedge. inject_at: cycle at which a second go is pulsed;
    // abort_at: cycle at which RST is pulled low. 0 disables either.
    task automatic run_seq(input logic [15:0] m, input int inject_at,
                           input logic [15:0] inject_mask, input int abort_at,
                           input string tag);
        obs_t e, last_e;
        int   cyc;
        bit   aborted;
        aborted = 1'b0;
        last_e  = '0;
        exp_q.delete();
        build_expect(m);
        go = 1'b1; core_mask = m;
        @(negedge clock);
        go = 1'b0; core_mask = ~m;   // mask changes while busy must not matter
        cyc = 2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_e = e;
            check(tag, cyc, e);
            if (e.valid)
                $display("[TB] %s cyc=%0d op=%b core=%0d addr=%h", tag, cyc, e.op, e.id, e.addr);
            if (cyc == abort_at) begin
                RST = 1'b0;
                aborted = 1'b1;
                exp_q.delete();
            end else if (cyc == inject_at) begin
                go = 1'b1; core_mask = inject_mask;
            end
            @(negedge clock);
            go = 1'b0;
            cyc++;
        end
        if (aborted) begin
            check({tag, "_rst"}, cyc, obs_t'(0));
            RST = 1'b1;
            exp_last_id = 4'd0;
            @(negedge clock);
            check({tag, "_idle"}, cyc + 1, obs_t'(0));
        end else begin
            check({tag, "_hold"}, cyc, last_e);
            @(negedge clock);
            check({tag, "_hold"}, cyc + 1, last_e);
        end
    endtask

    initial begin
        logic [15:0] rmask;
        RST = 1'b0; go = 1'b0; core_mask = 16'h0000;

        // Reset held two cycles, then released with no go.
        @(negedge clock); check("reset", 0, obs_t'(0));
        @(negedge clock); check("reset", 1, obs_t'(0));
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); check("idle", i, obs_t'(0));
        end

        run_seq(16'hFFFF, 0, 16'h0, 0, "full");
        run_seq(16'h8001, 0, 16'h0, 0, "ends");
        run_seq(16'h0000, 0, 16'h0, 0, "empty");
        run_seq(16'h0001, 0, 16'h0, 0, "single");
        run_seq(16'hA5A5, 0, 16'h0, 0, "sparse");
        // Third start command is at cycle 2+16+SETTLE+2 after go.
        run_seq(16'hFFFF, 24 + RTC, 16'h0003, 0, "go_busy");
        run_seq(16'hFFFF, 0, 16'h0, 24 + RTC, "abort");
        run_seq(16'h00F0, 0, 16'h0, 0, "restart");
        rmask = 16'($urandom_range(1, 16'hFFFF));
        run_seq(rmask, 0, 16'h0, 0, "random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
